// File: rtl/plate_region_locator.sv
// Licence-plate region locator.
// Builds a bounding box from the candidate pixels of the binary mask stream.
// A row joins the box only if it holds at least ROW_MIN_HITS candidates.
// The box is published at each frame boundary.
// The previous frame's box is drawn onto the delayed RGB stream.
//
// state      | meaning
// -----------+---------------------------------------------------------
// WAIT_FRAME | after reset; nothing is counted until the first boundary
// ACTIVE     | counting pixels/rows; every boundary publishes the box
module plate_region_locator #(
   parameter int unsigned         COORD_W      = 12,
   parameter logic [COORD_W-1:0]  ROW_MIN_HITS = COORD_W'(20),
   parameter logic                VS_POL       = 1'b1,
   parameter logic [23:0]         BOX_COLOR    = 24'hFF0000
) (
   input  logic               pix_clk,
   input  logic               reset_n,
   input  logic [23:0]        i_binary,
   input  logic [23:0]        i_rgb,
   input  logic               i_h_sync,
   input  logic               i_v_sync,
   input  logic               i_de,
   output logic [23:0]        o_rgb,
   output logic               o_h_sync,
   output logic               o_v_sync,
   output logic               o_de,
   output logic [COORD_W-1:0] box_x_min,
   output logic [COORD_W-1:0] box_x_max,
   output logic [COORD_W-1:0] box_y_min,
   output logic [COORD_W-1:0] box_y_max,
   output logic               box_found,
   output logic               box_valid
);

   typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

   localparam logic [COORD_W-1:0] C_MAX = '1;
   localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

   state_t             state_q, state_d;
   logic               de_q, vs_q;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic [COORD_W-1:0] row_hits_q, row_hits_d;
   logic [COORD_W-1:0] row_xmin_q, row_xmin_d, row_xmax_q, row_xmax_d;
   logic [COORD_W-1:0] fx_min_q, fx_min_d, fx_max_q, fx_max_d;
   logic [COORD_W-1:0] fy_min_q, fy_min_d, fy_max_q, fy_max_d;
   logic               frame_any_q, frame_any_d;
   logic [COORD_W-1:0] bx_min_q, bx_min_d, bx_max_q, bx_max_d;
   logic [COORD_W-1:0] by_min_q, by_min_d, by_max_q, by_max_d;
   logic               bfound_q, bfound_d, bvalid_q, bvalid_d;
   logic [23:0]        rgb_q, rgb_d;
   logic               hs_q, vso_q, deo_q;

   logic               boundary, de_fall, cand;
   logic [COORD_W-1:0] pix_x, pix_y;
   logic               on_col, on_row, on_border;

   assign boundary = (i_v_sync == VS_POL) && (vs_q != VS_POL);
   assign de_fall  = de_q && !i_de;
   assign cand     = (i_binary == 24'h000000);

   // Frame-phase FSM, coordinate counters, row stage, frame accumulator and publish.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      row_hits_d  = row_hits_q;
      row_xmin_d  = row_xmin_q;
      row_xmax_d  = row_xmax_q;
      fx_min_d    = fx_min_q;
      fx_max_d    = fx_max_q;
      fy_min_d    = fy_min_q;
      fy_max_d    = fy_max_q;
      frame_any_d = frame_any_q;
      bx_min_d    = bx_min_q;
      bx_max_d    = bx_max_q;
      by_min_d    = by_min_q;
      by_max_d    = by_max_q;
      bfound_d    = bfound_q;
      bvalid_d    = 1'b0;
      pix_x       = x_q;
      pix_y       = y_q;

      if (boundary) begin
         state_d = ACTIVE;
         pix_x   = '0;
         pix_y   = '0;
         // The very first boundary after reset only arms counting.
         if (state_q == ACTIVE) begin
            bvalid_d = 1'b1;
            bfound_d = frame_any_q;
            bx_min_d = frame_any_q ? fx_min_q : '0;
            bx_max_d = frame_any_q ? fx_max_q : '0;
            by_min_d = frame_any_q ? fy_min_q : '0;
            by_max_d = frame_any_q ? fy_max_q : '0;
         end
         fx_min_d    = C_MAX;
         fx_max_d    = '0;
         fy_min_d    = '0;
         fy_max_d    = '0;
         frame_any_d = 1'b0;
         y_d         = '0;
         x_d         = '0;
         // An open row is dropped; a pixel on this cycle opens the new frame at (0,0).
         row_hits_d  = '0;
         row_xmin_d  = C_MAX;
         row_xmax_d  = '0;
         if (i_de) begin
            x_d = C_ONE;
            if (cand) begin
               row_hits_d = C_ONE;
               row_xmin_d = '0;
               row_xmax_d = '0;
            end
         end
      end else if (state_q == ACTIVE) begin
         if (i_de) begin
            if (cand) begin
               if (row_hits_q != C_MAX) row_hits_d = row_hits_q + C_ONE;
               if (x_q < row_xmin_q)    row_xmin_d = x_q;
               if (x_q > row_xmax_q)    row_xmax_d = x_q;
            end
            if (x_q != C_MAX) x_d = x_q + C_ONE;
         end else if (de_fall) begin
            if (row_hits_q >= ROW_MIN_HITS) begin
               if (row_xmin_q < fx_min_q) fx_min_d = row_xmin_q;
               if (row_xmax_q > fx_max_q) fx_max_d = row_xmax_q;
               if (!frame_any_q)          fy_min_d = y_q;
               fy_max_d    = y_q;
               frame_any_d = 1'b1;
            end
            row_hits_d = '0;
            row_xmin_d = C_MAX;
            row_xmax_d = '0;
            x_d        = '0;
            if (y_q != C_MAX) y_d = y_q + C_ONE;
         end
      end
   end

   // Border test of the incoming pixel against the currently published box.
   always_comb begin
      on_col    = ((pix_x == bx_min_q) || (pix_x == bx_max_q)) &&
                  (pix_y >= by_min_q) && (pix_y <= by_max_q);
      on_row    = ((pix_y == by_min_q) || (pix_y == by_max_q)) &&
                  (pix_x >= bx_min_q) && (pix_x <= bx_max_q);
      on_border = bfound_q && (on_col || on_row);
      rgb_d     = 24'h000000;
      if (i_de) rgb_d = on_border ? BOX_COLOR : i_rgb;
   end

   // State and datapath registers.
   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= WAIT_FRAME;
         de_q        <= 1'b0;
         vs_q        <= ~VS_POL;
         x_q         <= '0;
         y_q         <= '0;
         row_hits_q  <= '0;
         row_xmin_q  <= C_MAX;
         row_xmax_q  <= '0;
         fx_min_q    <= C_MAX;
         fx_max_q    <= '0;
         fy_min_q    <= '0;
         fy_max_q    <= '0;
         frame_any_q <= 1'b0;
         bx_min_q    <= '0;
         bx_max_q    <= '0;
         by_min_q    <= '0;
         by_max_q    <= '0;
         bfound_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         rgb_q       <= 24'h000000;
         hs_q        <= 1'b0;
         vso_q       <= 1'b0;
         deo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         de_q        <= i_de;
         vs_q        <= i_v_sync;
         x_q         <= x_d;
         y_q         <= y_d;
         row_hits_q  <= row_hits_d;
         row_xmin_q  <= row_xmin_d;
         row_xmax_q  <= row_xmax_d;
         fx_min_q    <= fx_min_d;
         fx_max_q    <= fx_max_d;
         fy_min_q    <= fy_min_d;
         fy_max_q    <= fy_max_d;
         frame_any_q <= frame_any_d;
         bx_min_q    <= bx_min_d;
         bx_max_q    <= bx_max_d;
         by_min_q    <= by_min_d;
         by_max_q    <= by_max_d;
         bfound_q    <= bfound_d;
         bvalid_q    <= bvalid_d;
         rgb_q       <= rgb_d;
         hs_q        <= i_h_sync;
         vso_q       <= i_v_sync;
         deo_q       <= i_de;
      end
   end

   assign o_rgb     = rgb_q;
   assign o_h_sync  = hs_q;
   assign o_v_sync  = vso_q;
   assign o_de      = deo_q;
   assign box_x_min = bx_min_q;
   assign box_x_max = bx_max_q;
   assign box_y_min = by_min_q;
   assign box_y_max = by_max_q;
   assign box_found = bfound_q;
   assign box_valid = bvalid_q;

endmodule

// File: tb/tb_plate_region_locator.sv
// Directed bench for plate_region_locator: frame patterns with hand-computed boxes.
module tb_plate_region_locator;

   logic        pix_clk = 1'b0;
   logic        reset_n;
   logic [23:0] i_binary, i_rgb;
   logic        i_h_sync, i_v_sync, i_de;
   logic [23:0] o_rgb;
   logic        o_h_sync, o_v_sync, o_de;
   logic [11:0] box_x_min, box_x_max, box_y_min, box_y_max;
   logic        box_found, box_valid;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      int          pat;
      logic [11:0] xmin, xmax, ymin, ymax;
      logic        found;
   } vec_t;

   vec_t tab[5];

   logic [11:0] cur_xmin = 0, cur_xmax = 0, cur_ymin = 0, cur_ymax = 0;
   logic        cur_found = 0;
   logic [11:0] pend_xmin = 0, pend_xmax = 0, pend_ymin = 0, pend_ymax = 0;
   logic        pend_found = 0;

   plate_region_locator dut (
      .pix_clk(pix_clk), .reset_n(reset_n),
      .i_binary(i_binary), .i_rgb(i_rgb),
      .i_h_sync(i_h_sync), .i_v_sync(i_v_sync), .i_de(i_de),
      .o_rgb(o_rgb), .o_h_sync(o_h_sync), .o_v_sync(o_v_sync), .o_de(o_de),
      .box_x_min(box_x_min), .box_x_max(box_x_max),
      .box_y_min(box_y_min), .box_y_max(box_y_max),
      .box_found(box_found), .box_valid(box_valid)
   );

   always #5 pix_clk = ~pix_clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   function automatic logic is_cand(input int pat, input int x, input int y);
      case (pat)
         0: return (y >= 2 && y <= 5 && x >= 10 && x <= 39);
         1: return (y == 3 && x < 19);
         2: return (y == 1 && x >= 5 && x <= 30) || (y == 6 && x >= 20 && x <= 50);
         4: return (y == 7 && x >= 40 && x <= 59);
         5: return (x >= 4080);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [23:0] exp_rgb(input logic [11:0] x, input logic [11:0] y,
                                           input logic [23:0] rgb);
      logic col, row;
      col = (x == cur_xmin || x == cur_xmax) && y >= cur_ymin && y <= cur_ymax;
      row = (y == cur_ymin || y == cur_ymax) && x >= cur_xmin && x <= cur_xmax;
      return (cur_found && (col || row)) ? 24'hFF0000 : rgb;
   endfunction

   task automatic drive(input logic de, input logic vs, input logic hs,
                        input logic [23:0] bin, input logic [23:0] rgb);
      i_de = de; i_v_sync = vs; i_h_sync = hs; i_binary = bin; i_rgb = rgb;
      @(posedge pix_clk);
      #1;
   endtask

   task automatic pix(input logic de, input logic vs, input logic hs,
                      input logic [23:0] bin, input logic [23:0] rgb);
      drive(de, vs, hs, bin, rgb);
      chk("o_de", o_de, de);
      chk("o_v_sync", o_v_sync, vs);
      chk("o_h_sync", o_h_sync, hs);
   endtask

   task automatic chk_box(input string tag);
      chk({tag, "_xmin"}, box_x_min, cur_xmin);
      chk({tag, "_xmax"}, box_x_max, cur_xmax);
      chk({tag, "_ymin"}, box_y_min, cur_ymin);
      chk({tag, "_ymax"}, box_y_max, cur_ymax);
      chk({tag, "_found"}, box_found, cur_found);
   endtask

   task automatic frame_start(input logic pulse);
      pix(1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h0);
      chk("box_valid_edge", box_valid, pulse);
      if (pulse) begin
         cur_xmin = pend_xmin; cur_xmax = pend_xmax;
         cur_ymin = pend_ymin; cur_ymax = pend_ymax; cur_found = pend_found;
      end
      chk_box("pub");
      chk("o_rgb_blank", o_rgb, 24'h0);
      pix(1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h0);
      chk("box_valid_1cyc", box_valid, 1'b0);
      pix(1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h0);
      pix(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h0);
   endtask

   task automatic row(input int pat, input int y, input int w);
      logic [11:0] xv, yv;
      logic [23:0] rgb;
      for (int x = 0; x < w; x++) begin
         xv  = (x > 4095) ? 12'hFFF : x[11:0];
         yv  = y[11:0];
         rgb = {4'h3, xv, yv[7:0]};
         pix(1'b1, 1'b0, 1'b0, is_cand(pat, x, y) ? 24'h000000 : 24'hFFFFFF, rgb);
         chk("o_rgb", o_rgb, exp_rgb(xv, yv, rgb));
      end
      pix(1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'h123456);
      chk("o_rgb_de_low", o_rgb, 24'h0);
      chk("box_valid_mid", box_valid, 1'b0);
      chk_box("hold");
      pix(1'b0, 1'b0, 1'b1, 24'hFFFFFF, 24'h0);
      pix(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h0);
   endtask

   task automatic frame_rows(input int pat);
      for (int y = 0; y < 8; y++) row(pat, y, 64);
   endtask

   task automatic set_pend(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d, input logic f);
      pend_xmin = a; pend_xmax = b; pend_ymin = c; pend_ymax = d; pend_found = f;
   endtask

   initial begin
      tab[0] = '{0, 12'd10, 12'd39, 12'd2, 12'd5, 1'b1};
      tab[1] = '{1, 12'd0,  12'd0,  12'd0, 12'd0, 1'b0};
      tab[2] = '{2, 12'd5,  12'd50, 12'd1, 12'd6, 1'b1};
      tab[3] = '{3, 12'd0,  12'd0,  12'd0, 12'd0, 1'b0};
      tab[4] = '{4, 12'd40, 12'd59, 12'd7, 12'd7, 1'b1};

      reset_n = 1'b0;
      i_de = 0; i_v_sync = 0; i_h_sync = 0; i_binary = 24'hFFFFFF; i_rgb = 0;
      repeat (3) @(posedge pix_clk);
      #1 reset_n = 1'b1;
      pix(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h0);

      // Arm, start a frame, then reset in the middle of a row.
      frame_start(1'b0);
      row(3, 0, 64);
      for (int x = 0; x < 30; x++) drive(1'b1, 1'b0, 1'b1, 24'h000000, 24'hABCDEF);
      reset_n = 1'b0;
      #1;
      chk("rst_o_rgb", o_rgb, 24'h0);
      chk("rst_o_de", o_de, 1'b0);
      chk("rst_o_h_sync", o_h_sync, 1'b0);
      chk("rst_o_v_sync", o_v_sync, 1'b0);
      chk("rst_valid", box_valid, 1'b0);
      chk_box("rst");
      drive(1'b1, 1'b1, 1'b1, 24'h000000, 24'hABCDEF);
      chk("rst_hold_o_de", o_de, 1'b0);
      chk("rst_hold_valid", box_valid, 1'b0);
      reset_n = 1'b1;
      pix(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h0);
      pix(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h0);
      frame_start(1'b0);
      frame_rows(3);
      set_pend(0, 0, 0, 0, 0);

      // Table: each frame publishes the previous entry's box and shows it as overlay.
      for (int i = 0; i < 5; i++) begin
         frame_start(1'b1);
         frame_rows(tab[i].pat);
         set_pend(tab[i].xmin, tab[i].xmax, tab[i].ymin, tab[i].ymax, tab[i].found);
      end
      frame_start(1'b1);
      frame_rows(3);
      set_pend(0, 0, 0, 0, 0);

      // Boundary while de is high in row 4 holding 25 candidates.
      frame_start(1'b1);
      for (int y = 0; y < 4; y++) row(3, y, 64);
      for (int x = 0; x < 30; x++)
         pix(1'b1, 1'b0, 1'b0, (x < 25) ? 24'h000000 : 24'hFFFFFF, 24'h111111);
      pix(1'b1, 1'b1, 1'b0, 24'h000000, 24'h111111);
      chk("midrow_valid", box_valid, 1'b1);
      cur_xmin = 0; cur_xmax = 0; cur_ymin = 0; cur_ymax = 0; cur_found = 0;
      chk_box("midrow");
      for (int x = 1; x < 20; x++) pix(1'b1, 1'b1, 1'b0, 24'h000000, 24'h111111);
      pix(1'b0, 1'b1, 1'b0, 24'hFFFFFF, 24'h0);
      pix(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h0);
      pix(1'b0, 1'b0, 1'b0, 24'hFFFFFF, 24'h0);
      set_pend(0, 19, 0, 0, 1);

      // Over-long line: x saturates at 4095.
      frame_start(1'b1);
      row(5, 0, 4100);
      set_pend(12'd4080, 12'd4095, 0, 0, 1);

      // De falls on the boundary cycle: row y=1 with 25 candidates is discarded.
      for (int x = 0; x < 25; x++) pix(1'b1, 1'b0, 1'b0, 24'h000000, 24'h222222);
      frame_start(1'b1);
      frame_rows(3);
      set_pend(0, 0, 0, 0, 0);
      frame_start(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
